// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for a 5-stage RV32I pipeline
// Memory stalls outrank redirects, which outrank load-use stalls; counters saturate.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_mem,
  input  logic             jump_mem,
  input  logic             mem_read_mem,
  input  logic             mem_write_mem,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          mem_op;
  logic          in_wait;
  logic          mem_stall;
  logic          timeout;
  logic          redirect;
  logic          load_use;

  always_comb begin
    mem_op    = mem_read_mem | mem_write_mem;
    in_wait   = (state == MEM_WAIT);
    timeout   = in_wait && !dmem_ack && (wait_cnt == WAIT_LAST);
    // wait_cnt stays 0 in RUN, so the first stalled cycle enters MEM_WAIT at 1
    mem_stall = !dmem_ack && ((!in_wait && mem_op) || (in_wait && (wait_cnt != WAIT_LAST)));
    redirect  = !mem_stall && (branch_taken_mem || jump_mem);
    load_use  = !mem_stall && !redirect && mem_read_ex && (rd_ex != 5'd0) &&
                ((uses_rs1_id && (rs1_id == rd_ex)) || (uses_rs2_id && (rs2_id == rd_ex)));

    // Gating with rst_n makes every control output drop the moment reset asserts
    pc_en        = rst_n && !mem_stall && !load_use;
    if_id_en     = rst_n && !mem_stall && !load_use;
    id_ex_en     = rst_n && !mem_stall;
    ex_mem_en    = rst_n && !mem_stall;
    mem_wb_en    = rst_n;
    if_id_flush  = rst_n && redirect;
    id_ex_flush  = rst_n && (redirect || load_use);
    ex_mem_flush = rst_n && redirect;
    mem_wb_flush = rst_n && mem_stall;
    dmem_req     = rst_n && (in_wait || mem_op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_stall) begin
        state    <= MEM_WAIT;
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        state    <= RUN;
        wait_cnt <= '0;
      end
      if (timeout) begin
        mem_err <= 1'b1;
      end
      if (!pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Directed hazard scenarios followed by random traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic uses_rs1_id, uses_rs2_id, mem_read_ex, branch_taken_mem, jump_mem;
  logic mem_read_mem, mem_write_mem, dmem_ack;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, dmem_req, mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_dmem_req, s_mem_err;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  bit     m_wait;
  int     m_waited;
  bit     m_err;
  longint m_stall;
  longint m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .branch_taken_mem(branch_taken_mem), .jump_mem(jump_mem),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .dmem_req(dmem_req),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .branch_taken_mem(branch_taken_mem), .jump_mem(jump_mem),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .dmem_ack(dmem_ack),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
    .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush), .dmem_req(s_dmem_req),
    .mem_err(s_mem_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  wire [10:0] obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, dmem_req, mem_err};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_ex = 0; uses_rs1_id = 0; uses_rs2_id = 0;
    mem_read_ex = 0; branch_taken_mem = 0; jump_mem = 0;
    mem_read_mem = 0; mem_write_mem = 0; dmem_ack = 0;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cyc(input string tag);
    bit busy, mstall, tout, redir, lu, adv;
    logic [10:0] exp;
    #1;
    busy   = m_wait || mem_read_mem || mem_write_mem;
    mstall = busy && !dmem_ack && (m_waited < TO - 1);
    tout   = m_wait && !dmem_ack && (m_waited == TO - 1);
    redir  = !mstall && (branch_taken_mem || jump_mem);
    lu     = !mstall && !redir && mem_read_ex && (rd_ex != 0) &&
             ((uses_rs1_id && rs1_id == rd_ex) || (uses_rs2_id && rs2_id == rd_ex));
    adv    = !mstall && !lu;
    exp = {adv, adv, !mstall, !mstall, 1'b1, redir, redir || lu, redir, mstall, busy, m_err};
    chk({tag, "_ctrl"}, 64'(obs), 64'(exp));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
    chk({tag, "_sat_stall"}, 64'(s_stall_cnt), (m_stall > 3) ? 64'd3 : 64'(m_stall));
    chk({tag, "_sat_flush"}, 64'(s_flush_cnt), (m_flush > 3) ? 64'd3 : 64'(m_flush));
    if (mstall) begin m_wait = 1; m_waited++; end
    else begin m_wait = 0; m_waited = 0; end
    if (tout) m_err = 1;
    if (!adv) m_stall++;
    if (redir) m_flush++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 64'(obs), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_flush_cnt", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle");

    // load-use on rs1: exactly one bubble
    mem_read_ex = 1; rd_ex = 5; rs1_id = 5; uses_rs1_id = 1;
    cyc("lu");
    chk("lu_stall_cnt_abs", 64'(stall_cnt), 64'd1);
    idle();
    cyc("lu_after");

    mem_read_ex = 1; rd_ex = 0; rs1_id = 0; uses_rs1_id = 1;
    cyc("lu_x0");
    idle(); mem_read_ex = 1; rd_ex = 7; rs2_id = 7; uses_rs2_id = 0; uses_rs1_id = 1; rs1_id = 3;
    cyc("lu_rs2_unused");
    idle(); mem_read_ex = 1; rd_ex = 9; rs2_id = 9; uses_rs2_id = 1;
    cyc("lu_rs2");

    idle(); branch_taken_mem = 1;
    cyc("branch");
    chk("branch_flush_cnt_abs", 64'(flush_cnt), 64'd1);
    jump_mem = 1; branch_taken_mem = 0; mem_read_ex = 1; rd_ex = 5; rs1_id = 5; uses_rs1_id = 1;
    #1 chk("redir_over_lu_pc_en", 64'(pc_en), 64'd1);
    cyc("jump_lu");
    idle();
    cyc("idle2");

    // three unacknowledged cycles then ack
    mem_read_mem = 1;
    repeat (3) cyc("memwait");
    dmem_ack = 1;
    cyc("memack");
    chk("memwait_stall_abs", 64'(stall_cnt), 64'd5);
    idle();
    cyc("idle3");

    // timeout with a redirect arriving mid-wait
    mem_write_mem = 1;
    for (int i = 0; i < TO; i++) begin
      branch_taken_mem = (i >= 4 && i < 8);
      cyc("timeout");
    end
    chk("timeout_err", 64'(mem_err), 64'd1);
    idle();
    cyc("post_timeout");

    // reset while waiting
    mem_read_mem = 1;
    repeat (2) cyc("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'(obs), 64'd0);
    chk("async_reset_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle();
    cyc("after_reset");

    for (int n = 0; n < 800; n++) begin
      rs1_id = 5'($urandom_range(0, 3));
      rs2_id = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3));
      uses_rs1_id = 1'($urandom_range(0, 1));
      uses_rs2_id = 1'($urandom_range(0, 1));
      mem_read_ex = 1'($urandom_range(0, 1));
      branch_taken_mem = ($urandom_range(0, 7) == 0);
      jump_mem = ($urandom_range(0, 11) == 0);
      mem_read_mem = ($urandom_range(0, 3) == 0);
      mem_write_mem = ($urandom_range(0, 5) == 0);
      dmem_ack = (n >= 400 && n < 440) ? 1'b0 : ($urandom_range(0, 2) == 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
